// File: rtl/mem_uart_bus_ctrl.sv
// rtl/mem_uart_bus_ctrl.sv - EXE-stage data-memory controller for one async SRAM plus a memory-mapped UART
// One load/store in flight; strobes decode from the state register so an async reset drops them at once.
module mem_uart_bus_ctrl #(
  parameter int                 ADDR_W         = 18,
  parameter int                 DATA_W         = 16,
  parameter int                 WAIT_CYCLES    = 1,
  parameter logic [ADDR_W-1:0]  UART_DATA_ADDR = 18'h0BF00,
  parameter logic [ADDR_W-1:0]  UART_STAT_ADDR = 18'h0BF01,
  parameter int                 UART_TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_rd,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_en,
  output logic              ram_oe,
  output logic              ram_we,
  input  logic              uart_data_ready,
  input  logic              uart_tbre,
  input  logic              uart_tsre,
  output logic              uart_rdn,
  output logic              uart_wrn,
  output logic [3:0]        status
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int TO_W  = (UART_TIMEOUT > 0) ? $clog2(UART_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST  = (UART_TIMEOUT > 0) ? TO_W'(UART_TIMEOUT - 1) : TO_W'(0);

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_RAM_RD       = 4'd1,
    S_RAM_WR_SETUP = 4'd2,
    S_RAM_WR       = 4'd3,
    S_UART_RD_WAIT = 4'd4,
    S_UART_RD      = 4'd5,
    S_UART_WR_WAIT = 4'd6,
    S_UART_WR      = 4'd7,
    S_DONE         = 4'd8
  } state_e;

  typedef enum logic [1:0] {
    T_RAM   = 2'd0,
    T_UDATA = 2'd1,
    T_USTAT = 2'd2
  } tgt_e;

  state_e            state_q, state_d;
  tgt_e              tgt_q, tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              bus_oe;
  logic [DATA_W-1:0] bus_dout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      tgt_q   <= T_RAM;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    case (state_q)
      S_IDLE: begin
        if (req_rd || req_wr) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wr_d    = req_wr;
          err_d   = 1'b0;
          cnt_d   = CNT_LOAD;
          to_d    = '0;
          if (req_addr == UART_DATA_ADDR) begin
            tgt_d   = T_UDATA;
            state_d = req_wr ? S_UART_WR_WAIT : S_UART_RD_WAIT;
          end else if (req_addr == UART_STAT_ADDR) begin
            tgt_d   = T_USTAT;
            state_d = S_DONE;
            // Status is a snapshot at accept so the read completes in one cycle.
            if (!req_wr) begin
              rdata_d    = '0;
              rdata_d[1] = uart_data_ready;
              rdata_d[0] = uart_tbre & uart_tsre;
            end
          end else begin
            tgt_d   = T_RAM;
            state_d = req_wr ? S_RAM_WR_SETUP : S_RAM_RD;
          end
        end
      end
      S_RAM_RD: begin
        if (cnt_q == '0) begin
          rdata_d = ram_data;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RAM_WR_SETUP: state_d = S_RAM_WR;
      S_RAM_WR: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_UART_RD_WAIT: begin
        if (uart_data_ready) begin
          state_d = S_UART_RD;
        end else if (UART_TIMEOUT > 0) begin
          if (to_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      S_UART_RD: begin
        if (cnt_q == '0) begin
          rdata_d      = '0;
          rdata_d[7:0] = ram_data[7:0];
          state_d      = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_UART_WR_WAIT: begin
        if (uart_tbre && uart_tsre) begin
          state_d = S_UART_WR;
        end else if (UART_TIMEOUT > 0) begin
          if (to_q == TO_LAST) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      S_UART_WR: begin
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_dout = wdata_q;
    if (tgt_q == T_UDATA) begin
      bus_dout      = '0;
      bus_dout[7:0] = wdata_q[7:0];
    end
    // DONE keeps write data on the bus one extra cycle as hold time; a timed-out UART write never drives.
    bus_oe = (state_q == S_RAM_WR_SETUP) || (state_q == S_RAM_WR) || (state_q == S_UART_WR) ||
             ((state_q == S_DONE) && wr_q &&
              ((tgt_q == T_RAM) || ((tgt_q == T_UDATA) && !err_q)));
  end

  assign ram_data = bus_oe ? bus_dout : {DATA_W{1'bz}};

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_en   = !((state_q == S_RAM_RD) || (state_q == S_RAM_WR_SETUP) || (state_q == S_RAM_WR) ||
                      ((state_q == S_DONE) && wr_q && (tgt_q == T_RAM)));
  assign ram_oe   = (state_q != S_RAM_RD);
  assign ram_we   = (state_q != S_RAM_WR);
  assign uart_rdn = (state_q != S_UART_RD);
  assign uart_wrn = (state_q != S_UART_WR);
  assign status   = state_q;

endmodule

// File: tb/tb_mem_uart_bus_ctrl.sv
// tb/tb_mem_uart_bus_ctrl.sv - directed-vector bench for mem_uart_bus_ctrl with SRAM/UART bus model
module tb_mem_uart_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [17:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        busy, done, err;
  logic [15:0] rdata;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_en, ram_oe, ram_we;
  logic        uart_data_ready = 1'b0;
  logic        uart_tbre = 1'b1;
  logic        uart_tsre = 1'b1;
  logic        uart_rdn, uart_wrn;
  logic [3:0]  status;

  logic [15:0] mem [0:63];
  logic [15:0] uart_rx = 16'h0000;
  logic        tb_oe;
  logic [15:0] tb_dout;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0, oe_cnt = 0, rdn_cnt = 0, wrn_cnt = 0, en_cnt = 0;
  logic [15:0] we_bus = '0, wrn_bus = '0;

  always #5 clk = ~clk;

  mem_uart_bus_ctrl #(
    .ADDR_W(18), .DATA_W(16), .WAIT_CYCLES(1),
    .UART_DATA_ADDR(18'h0BF00), .UART_STAT_ADDR(18'h0BF01), .UART_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_en(ram_en), .ram_oe(ram_oe),
    .ram_we(ram_we), .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre),
    .uart_tsre(uart_tsre), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .status(status)
  );

  always_comb begin
    tb_oe   = 1'b0;
    tb_dout = 16'h0000;
    if (!ram_en && !ram_oe) begin
      tb_oe   = 1'b1;
      tb_dout = mem[ram_addr[5:0]];
    end else if (!uart_rdn) begin
      tb_oe   = 1'b1;
      tb_dout = uart_rx;
    end
  end
  assign ram_data = tb_oe ? tb_dout : 16'hzzzz;

  always @(negedge clk) begin
    if (!ram_we) begin
      we_cnt <= we_cnt + 1;
      we_bus <= ram_data;
      if (!ram_en) mem[ram_addr[5:0]] <= ram_data;
    end
    if (!ram_oe)   oe_cnt  <= oe_cnt + 1;
    if (!uart_rdn) rdn_cnt <= rdn_cnt + 1;
    if (!uart_wrn) begin
      wrn_cnt <= wrn_cnt + 1;
      wrn_bus <= ram_data;
    end
    if (!ram_en)   en_cnt  <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_access(input logic rd, input logic wr, input logic [17:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd_s, output logic er,
                           output logic [31:0] path, output int first_wrn);
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_addr = a; req_wdata = d;
    lat = 0; path = '0; first_wrn = 0; rd_s = '0; er = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      path = {path[27:0], status};
      if (!uart_wrn && first_wrn == 0) first_wrn = lat;
      if (done) begin
        rd_s = rdata;
        er   = err;
        break;
      end
    end
    req_rd = 1'b0;
    req_wr = 1'b0;
    if (!done) chk("access_bound", 32'd0, 32'd1);
  endtask

  int          lat, fw, c0, c1, c2, dn;
  logic [15:0] rv;
  logic        ev;
  logic [31:0] pth;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctl", {24'd0, busy, done, err, ram_en, ram_oe, ram_we, uart_rdn, uart_wrn}, 32'h1F);
    chk("rst_rdata", {16'd0, rdata}, 32'h0);
    chk("rst_addr_status", {10'd0, ram_addr, status}, 32'h0);
    rst = 1'b1;

    // SRAM write then read back
    c0 = we_cnt;
    do_access(1'b0, 1'b1, 18'h00010, 16'hBEEF, lat, rv, ev, pth, fw);
    chk("wr_lat", lat, 4);
    chk("wr_we_cycles", we_cnt - c0, 2);
    chk("wr_bus", {16'd0, we_bus}, 32'hBEEF);
    chk("wr_err", {31'd0, ev}, 32'h0);
    c0 = oe_cnt;
    do_access(1'b1, 1'b0, 18'h00010, 16'h0000, lat, rv, ev, pth, fw);
    chk("rd_lat", lat, 3);
    chk("rd_oe_cycles", oe_cnt - c0, 2);
    chk("rd_data", {16'd0, rv}, 32'hBEEF);
    chk("rd_path", pth, 32'h118);

    // UART write gated by tbre
    uart_tbre = 1'b0;
    c0 = wrn_cnt; c1 = en_cnt;
    fork
      do_access(1'b0, 1'b1, 18'h0BF00, 16'h1241, lat, rv, ev, pth, fw);
      begin
        repeat (6) @(negedge clk);
        uart_tbre = 1'b1;
      end
    join
    chk("uwr_lat", lat, 8);
    chk("uwr_first_wrn", fw, 6);
    chk("uwr_wrn_cycles", wrn_cnt - c0, 2);
    chk("uwr_bus", {16'd0, wrn_bus}, 32'h0041);
    chk("uwr_en_high", en_cnt - c1, 0);

    // Status read
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
    do_access(1'b1, 1'b0, 18'h0BF01, 16'h0000, lat, rv, ev, pth, fw);
    chk("stat_lat", lat, 1);
    chk("stat_data", {16'd0, rv}, 32'h0002);
    uart_tsre = 1'b1;

    // UART data read
    uart_rx = 16'hA5C3;
    c0 = rdn_cnt;
    do_access(1'b1, 1'b0, 18'h0BF00, 16'h0000, lat, rv, ev, pth, fw);
    chk("urd_lat", lat, 4);
    chk("urd_data", {16'd0, rv}, 32'h00C3);
    chk("urd_rdn_cycles", rdn_cnt - c0, 2);

    // UART read timeout
    uart_data_ready = 1'b0;
    c0 = rdn_cnt;
    do_access(1'b1, 1'b0, 18'h0BF00, 16'h0000, lat, rv, ev, pth, fw);
    chk("to_lat", lat, 9);
    chk("to_err", {31'd0, ev}, 32'h1);
    chk("to_rdata", {16'd0, rv}, 32'h0);
    chk("to_no_rdn", rdn_cnt - c0, 0);

    // Async reset in the middle of RAM_WR
    @(negedge clk);
    req_wr = 1'b1; req_addr = 18'h00030; req_wdata = 16'h1234;
    repeat (2) @(negedge clk);
    chk("mid_state", {28'd0, status}, 32'h3);
    req_wr = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_ctl", {28'd0, ram_we, ram_en, busy, done}, 32'hC);
    chk("async_status", {28'd0, status}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    dn = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk("post_rst_idle", dn, 0);

    // Simultaneous rd+wr behaves as a write
    do_access(1'b1, 1'b1, 18'h00020, 16'h5A3C, lat, rv, ev, pth, fw);
    chk("rw_path", pth, 32'h2338);
    chk("rw_lat", lat, 4);
    do_access(1'b1, 1'b0, 18'h00020, 16'h0000, lat, rv, ev, pth, fw);
    chk("rw_readback", {16'd0, rv}, 32'h5A3C);
    c2 = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
